// File: rtl/xbar_bank_arbiter.sv
// Bank-conflict scheduler for one crossbar port group; serialises lanes hitting one bank.
// Define XBAR_RR_EN for per-bank round-robin priority instead of fixed lowest-lane priority.
module xbar_bank_arbiter #(
  parameter int ADW   = 5,
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_mask,
  input  logic [3*LANES-1:0]    in_bank,
  input  logic [ADW*LANES-1:0]  in_addr,
  input  logic                  xbar_stall,
  output logic [ADW*LANES-1:0]  lane_addr,
  output logic [3*LANES-1:0]    bank_idx,
  output logic [LANES-1:0]      bank_en,
  output logic [LANES-1:0]      lane_grant,
  output logic                  batch_done,
  output logic                  busy
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               state_q;
  logic [LANES-1:0]     pend_q;
  logic [3*LANES-1:0]   bank_q;
  logic [ADW*LANES-1:0] addr_q;
  logic                 empty_q;

  logic                 issue;
  logic                 accept;
  logic                 done_d;
  logic [LANES-1:0]     en_d;
  logic [LANES-1:0]     gr_d;
  logic [3*LANES-1:0]   idx_d;

`ifdef XBAR_RR_EN
  logic [3*LANES-1:0]   ptr_q;
`endif

  // Scan in reverse priority order so the last match is the winner.
  always_comb begin
    logic [2:0] k;
    en_d  = '0;
    gr_d  = '0;
    idx_d = '0;
    k     = '0;
    issue = (state_q == ISSUE) & ~xbar_stall & ~rst;
    for (int j = 0; j < LANES; j++) begin
      for (int o = LANES - 1; o >= 0; o--) begin
`ifdef XBAR_RR_EN
        k = 3'(ptr_q[3*j +: 3] + 3'(o));
`else
        k = 3'(o);
`endif
        if (issue && pend_q[k] && bank_q[3*k +: 3] == 3'(j)) begin
          en_d[j]          = 1'b1;
          idx_d[3*j +: 3]  = k;
        end
      end
      if (en_d[j])
        gr_d[idx_d[3*j +: 3]] = 1'b1;
    end
    done_d = ~rst & (empty_q |
             (issue & ((pend_q & ~gr_d) == '0)));
  end

  assign in_ready   = ~rst & ((state_q == IDLE) | done_d);
  assign accept     = in_valid & in_ready;
  assign bank_en    = en_d;
  assign bank_idx   = idx_d;
  assign lane_grant = gr_d;
  assign batch_done = done_d;
  assign busy       = ~rst & (state_q == ISSUE);
  assign lane_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      bank_q  <= '0;
      addr_q  <= '0;
      empty_q <= 1'b0;
`ifdef XBAR_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      empty_q <= accept & ~|in_mask;
      if (issue)
        pend_q <= pend_q & ~gr_d;
`ifdef XBAR_RR_EN
      for (int j = 0; j < LANES; j++)
        if (en_d[j])
          ptr_q[3*j +: 3] <= idx_d[3*j +: 3] + 3'd1;
`endif
      if (accept) begin
        pend_q  <= in_mask;
        bank_q  <= in_bank;
        addr_q  <= in_addr;
        state_q <= (|in_mask) ? ISSUE : IDLE;
      end else if (done_d) begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_xbar_bank_arbiter.sv
// Scoreboard bench for xbar_bank_arbiter: per-cycle expectations queued at batch accept.
module tb_xbar_bank_arbiter;

  localparam int ADW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_mask = '0;
  logic [23:0]   in_bank = '0;
  logic [39:0]   in_addr = '0;
  logic          xbar_stall = 1'b0;
  logic [39:0]   lane_addr;
  logic [23:0]   bank_idx;
  logic [7:0]    bank_en;
  logic [7:0]    lane_grant;
  logic          batch_done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        stall;
    logic [7:0]  en;
    logic [23:0] idx;
    logic [7:0]  gr;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t        q[$];
  logic [2:0]  mptr[8];
  logic [39:0] exp_addr = '0;

  always #5 clk = ~clk;

  xbar_bank_arbiter #(.ADW(ADW), .LANES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_bank    (in_bank),
    .in_addr    (in_addr),
    .xbar_stall (xbar_stall),
    .lane_addr  (lane_addr),
    .bank_idx   (bank_idx),
    .bank_en    (bank_en),
    .lane_grant (lane_grant),
    .batch_done (batch_done),
    .busy       (busy)
  );

  function automatic logic [39:0] mk_addr(input int base);
    logic [39:0] a;
    a = '0;
    for (int k = 0; k < 8; k++)
      a[5*k +: 5] = 5'(base + k);
    return a;
  endfunction

  // Reference: per cycle, each bank serves its highest-priority pending lane.
  task automatic model_batch(input logic [7:0] mask, input logic [23:0] banks,
                             input int stall_at, input int stall_n);
    logic [7:0] pend;
    exp_t       e;
    int         cyc;
    int         best;
    pend = mask;
    if (mask == 8'h00) begin
      e = '0;
      e.done = 1'b1;
      q.push_back(e);
      return;
    end
    cyc = 0;
    while (pend != 8'h00) begin
      cyc++;
      if (cyc == stall_at)
        for (int i = 0; i < stall_n; i++) begin
          e = '0;
          e.stall = 1'b1;
          e.busy = 1'b1;
          q.push_back(e);
        end
      e = '0;
      e.busy = 1'b1;
      for (int j = 0; j < 8; j++) begin
        best = -1;
        for (int o = 0; o < 8; o++) begin
          int k;
`ifdef XBAR_RR_EN
          k = (int'(mptr[j]) + o) % 8;
`else
          k = o;
`endif
          if (best < 0 && pend[k] && banks[3*k +: 3] == j[2:0])
            best = k;
        end
        if (best >= 0) begin
          e.en[j] = 1'b1;
          e.idx[3*j +: 3] = best[2:0];
          e.gr[best] = 1'b1;
          mptr[j] = 3'((best + 1) % 8);
        end
      end
      pend &= ~e.gr;
      e.done = (pend == 8'h00);
      q.push_back(e);
    end
  endtask

  task automatic step_check(input string tag, input logic nv, input logic [7:0] m,
                            input logic [23:0] b, input logic [39:0] a);
    exp_t e;
    e = q.pop_front();
    @(negedge clk);
    xbar_stall = e.stall;
    in_valid = nv;
    in_mask = m;
    in_bank = b;
    in_addr = a;
    #1;
    total++;
    if ({bank_en, bank_idx, lane_grant, batch_done, busy} !==
        {e.en, e.idx, e.gr, e.done, e.busy}) begin
      bad++;
      $display("FAIL %s: got en=%h idx=%h gr=%h done=%b busy=%b want en=%h idx=%h gr=%h done=%b busy=%b",
               tag, bank_en, bank_idx, lane_grant, batch_done, busy,
               e.en, e.idx, e.gr, e.done, e.busy);
    end
    total++;
    if (lane_addr !== exp_addr) begin
      bad++;
      $display("FAIL %s lane_addr: got %h want %h", tag, lane_addr, exp_addr);
    end
    if (nv) begin
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s b2b in_ready: got %b want 1", tag, in_ready);
      end
      exp_addr = a;
      model_batch(m, b, 0, 0);
    end
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0)
      step_check(tag, 1'b0, 8'h00, 24'h0, 40'h0);
  endtask

  task automatic send(input string tag, input logic [7:0] m, input logic [23:0] b,
                      input logic [39:0] a, input int sa, input int sn);
    @(negedge clk);
    xbar_stall = 1'b0;
    in_valid = 1'b1;
    in_mask = m;
    in_bank = b;
    in_addr = a;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    exp_addr = a;
    model_batch(m, b, sa, sn);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    xbar_stall = 1'b0;
    #1;
    total++;
    if ({busy, bank_en, lane_grant, batch_done, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL %s idle: got busy=%b en=%h gr=%h done=%b rdy=%b want 0 00 00 0 1",
               tag, busy, bank_en, lane_grant, batch_done, in_ready);
    end
  endtask

  task automatic test_reset();
    for (int j = 0; j < 8; j++) mptr[j] = 3'd0;
    @(negedge clk);
    in_valid = 1'b1;
    in_mask = 8'hFF;
    #1;
    total++;
    if ({in_ready, busy, bank_en, lane_grant, bank_idx, batch_done} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got rdy=%b busy=%b en=%h gr=%h idx=%h done=%b want all 0",
               in_ready, busy, bank_en, lane_grant, bank_idx, batch_done);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, lane_addr} !== {1'b1, 1'b0, 40'h0}) begin
      bad++;
      $display("FAIL reset release: got rdy=%b busy=%b addr=%h want 1 0 0",
               in_ready, busy, lane_addr);
    end
  endtask

  task automatic test_identity();
    send("identity", 8'hFF, 24'o76543210, mk_addr(1), 0, 0);
    drain("identity");
    check_idle("identity");
  endtask

  task automatic test_full_conflict();
    send("conflict", 8'hFF, 24'o33333333, mk_addr(4), 0, 0);
    drain("conflict");
    check_idle("conflict");
  endtask

  task automatic test_partial();
    send("partial", 8'h0F, 24'o00005522, mk_addr(9), 0, 0);
    drain("partial");
    check_idle("partial");
  endtask

  task automatic test_stall();
    send("stall", 8'hFF, 24'o33333333, mk_addr(12), 3, 2);
    total++;
    if (q.size() != 10) begin
      bad++;
      $display("FAIL stall length: got %0d want 10", q.size());
    end
    drain("stall");
    check_idle("stall");
  endtask

  task automatic test_back_to_back();
    send("b2b_a", 8'h0F, 24'o00005522, mk_addr(3), 0, 0);
    while (q.size() > 1)
      step_check("b2b_a", 1'b0, 8'h00, 24'h0, 40'h0);
    step_check("b2b_a_done", 1'b1, 8'hFF, 24'o76543210, mk_addr(20));
    drain("b2b_b");
    check_idle("b2b");
  endtask

  task automatic test_reset_mid();
    send("rstmid", 8'hFF, 24'o33333333, mk_addr(7), 0, 0);
    for (int i = 0; i < 3; i++)
      step_check("rstmid", 1'b0, 8'h00, 24'h0, 40'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, bank_en, lane_grant, batch_done} !== '0) begin
      bad++;
      $display("FAIL rstmid during: got rdy=%b busy=%b en=%h gr=%h done=%b want all 0",
               in_ready, busy, bank_en, lane_grant, batch_done);
    end
    q.delete();
    for (int j = 0; j < 8; j++) mptr[j] = 3'd0;
    exp_addr = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, bank_en, lane_grant, lane_addr} !== {1'b1, 1'b0, 8'h00, 8'h00, 40'h0}) begin
      bad++;
      $display("FAIL rstmid after: got rdy=%b busy=%b en=%h gr=%h addr=%h want 1 0 00 00 0",
               in_ready, busy, bank_en, lane_grant, lane_addr);
    end
    check_idle("rstmid_quiet");
    send("empty", 8'h00, 24'o76543210, mk_addr(2), 0, 0);
    drain("empty");
    check_idle("empty");
  endtask

  task automatic test_rr();
    send("rr1", 8'h03, 24'o00000000, mk_addr(5), 0, 0);
    drain("rr1");
    send("rr2", 8'h03, 24'o00000000, mk_addr(6), 0, 0);
    drain("rr2");
    check_idle("rr");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_full_conflict();
    test_partial();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
